// File: rtl/pcs_tx_scr_gearbox.sv
// 10GBASE-R PCS transmit back end: scrambles 66b blocks (or generates test patterns) and
// emits 32/64-bit words with header and sequence count for an external-gearbox transceiver.
module pcs_tx_scr_gearbox #(
    parameter int          DATA_W   = 32,
    parameter int          SEQ_LAST = 32,
    parameter bit          BIT_REV  = 1'b1,
    parameter logic [57:0] SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic              cfg_scr_byp_i,
    input  logic [63:0]       blk_data_i,
    input  logic [1:0]        blk_head_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic [5:0]        head_o,
    output logic [6:0]        sequence_o,
    output logic              underrun_o
);

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_ZERO       = 2'b01,
        MODE_PRBS       = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } mode_t;

    localparam bit          WIDE       = (DATA_W == 64);
    localparam logic [6:0]  SEQ_END    = 7'(SEQ_LAST);
    localparam logic [63:0] IDLE_BLOCK = 64'h1E;

    mode_t              mode;
    logic               test_mode;
    logic               slot;
    logic               half;
    logic [6:0]         seq;
    logic [57:0]        scr;
    logic [57:0]        scr_next;
    logic [30:0]        prbs;
    logic [30:0]        prbs_next;
    logic [65:0]        prbs_bits;
    logic [63:0]        src_data;
    logic [1:0]         src_head;
    logic [63:0]        scr_data;
    logic [63:0]        blk_next;
    logic [63:0]        blk_q;
    logic [1:0]         head_q;
    logic               load_d;
    logic               hi_d;
    logic [DATA_W-1:0]  lo_word;
    logic [DATA_W-1:0]  hi_word;
    logic [DATA_W-1:0]  lo_fmt;
    logic [DATA_W-1:0]  hi_fmt;
    logic [1:0]         head_fmt;

    function automatic logic [DATA_W-1:0] reverse_word(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = w[DATA_W-1-i];
        end
        return r;
    endfunction

    assign mode      = mode_t'(cfg_mode_i);
    assign test_mode = (mode == MODE_ZERO) || (mode == MODE_PRBS);
    // A load slot is any non-pause cycle; on a 32-bit lane only the first half of each block.
    assign slot        = (seq != SEQ_END) && (WIDE || !half);
    assign blk_ready_o = rst_n_i && slot && !test_mode;
    assign underrun_o  = blk_ready_o && !blk_valid_i;
    assign sequence_o  = seq;

    always_comb begin
        src_data = IDLE_BLOCK;
        src_head = 2'b10;
        case (mode)
            MODE_ZERO: begin
                src_data = '0;
                src_head = 2'b01;
            end
            MODE_PRBS: begin
                src_data = prbs_bits[65:2];
                src_head = prbs_bits[1:0];
            end
            default: begin
                if (blk_valid_i) begin
                    src_data = blk_data_i;
                    src_head = blk_head_i;
                end
            end
        endcase
    end

    // Self-synchronous x^58+x^39+1 scrambler unrolled over the 64 payload bits, LSB first.
    always_comb begin
        logic [57:0] s;
        logic        b;
        s        = scr;
        b        = 1'b0;
        scr_data = '0;
        for (int i = 0; i < 64; i++) begin
            b           = src_data[i] ^ s[38] ^ s[57];
            scr_data[i] = b;
            s           = {s[56:0], b};
        end
        scr_next = s;
    end

    always_comb begin
        logic [30:0] p;
        logic        b;
        p         = prbs;
        b         = 1'b0;
        prbs_bits = '0;
        for (int i = 0; i < 66; i++) begin
            b            = p[30] ^ p[27];
            prbs_bits[i] = b;
            p            = {p[29:0], b};
        end
        prbs_next = p;
    end

    // Bypass skips only the XOR; the scrambler state still advances to stay in step with the far end.
    assign blk_next = ((mode == MODE_PRBS) || (cfg_scr_byp_i && !test_mode)) ? src_data : scr_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq    <= '0;
            half   <= 1'b0;
            scr    <= SCR_INIT;
            prbs   <= '1;
            blk_q  <= '0;
            head_q <= '0;
            load_d <= 1'b0;
            hi_d   <= 1'b0;
        end else begin
            if (WIDE || half) begin
                seq <= (seq == SEQ_END) ? 7'd0 : seq + 7'd1;
            end
            half   <= WIDE ? 1'b0 : !half;
            load_d <= slot;
            hi_d   <= load_d && !WIDE;
            if (slot) begin
                blk_q  <= blk_next;
                head_q <= src_head;
                if (mode == MODE_PRBS) begin
                    prbs <= prbs_next;
                end else begin
                    scr <= scr_next;
                end
            end
        end
    end

    always_comb begin
        lo_word  = DATA_W'(blk_q);
        hi_word  = DATA_W'(blk_q >> 32);
        lo_fmt   = lo_word;
        hi_fmt   = hi_word;
        head_fmt = head_q;
        if (BIT_REV) begin
            lo_fmt   = reverse_word(lo_word);
            hi_fmt   = reverse_word(hi_word);
            head_fmt = {head_q[0], head_q[1]};
        end
    end

    // Words change only when a freshly loaded block is presented; otherwise the last word holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= '0;
            head_o <= '0;
        end else if (load_d) begin
            data_o <= lo_fmt;
            head_o <= {4'b0000, head_fmt};
        end else if (hi_d) begin
            data_o <= hi_fmt;
            head_o <= '0;
        end
    end

endmodule

// File: tb/tb_pcs_tx_scr_gearbox.sv
// Self-checking bench: a 64-bit bypass instance driven from a hand-computed vector table, and a
// 32-bit bit-reversed instance checked against a descrambler / PRBS31 checker model.
module tb_pcs_tx_scr_gearbox;

    localparam logic [57:0] SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [6:0]  LAST32   = 7'd3;
    localparam logic [63:0] P1   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P2   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] P3   = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] P4   = 64'hA5A5_5A5A_F0F0_0F0F;
    localparam logic [63:0] P5   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] P6   = 64'h8000_0000_0000_0001;
    localparam logic [63:0] P7   = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] P8   = 64'hCAFE_F00D_DEAD_BEEF;
    localparam logic [63:0] IDLE = 64'h1E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  mode64 = 2'b00;
    logic        byp64 = 1'b1;
    logic [63:0] data64 = '0;
    logic [1:0]  head64 = '0;
    logic        valid64 = 1'b0;
    logic        ready64;
    logic [63:0] dout64;
    logic [5:0]  hout64;
    logic [6:0]  seq64;
    logic        und64;

    logic [1:0]  mode32 = 2'b00;
    logic        byp32 = 1'b0;
    logic [63:0] data32 = '0;
    logic [1:0]  head32 = '0;
    logic        valid32 = 1'b0;
    logic        ready32;
    logic [31:0] dout32;
    logic [5:0]  hout32;
    logic [6:0]  seq32;
    logic        und32;

    pcs_tx_scr_gearbox #(.DATA_W(64), .SEQ_LAST(4), .BIT_REV(1'b0), .SCR_INIT(SCR_INIT)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_mode_i(mode64), .cfg_scr_byp_i(byp64),
        .blk_data_i(data64), .blk_head_i(head64), .blk_valid_i(valid64), .blk_ready_o(ready64),
        .data_o(dout64), .head_o(hout64), .sequence_o(seq64), .underrun_o(und64)
    );

    pcs_tx_scr_gearbox #(.DATA_W(32), .SEQ_LAST(3), .BIT_REV(1'b1), .SCR_INIT(SCR_INIT)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_mode_i(mode32), .cfg_scr_byp_i(byp32),
        .blk_data_i(data32), .blk_head_i(head32), .blk_valid_i(valid32), .blk_ready_o(ready32),
        .data_o(dout32), .head_o(hout32), .sequence_o(seq32), .underrun_o(und32)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [63:0] data;
        logic [1:0]  head;
        logic        ready;
        logic        underrun;
        logic [6:0]  seq;
        logic [63:0] dout;
        logic [5:0]  hout;
    } vec_t;

    vec_t vecs[16];

    task automatic applyStimulus(input vec_t v);
        valid64 = v.valid;
        data64  = v.data;
        head64  = v.head;
    endtask

    // 32-bit lane reference: counters, expected block queue, descrambler and PRBS31 checker.
    typedef struct {
        int          cyc;
        logic        prbs;
        logic [63:0] data;
        logic [1:0]  head;
    } blk_t;

    blk_t        q[$];
    int          cyc = 0;
    logic [6:0]  seq_m = '0;
    logic        half_m = 1'b0;
    logic [31:0] low_m = '0;
    logic [1:0]  hdr_m = '0;
    logic [31:0] last_dout = '0;
    logic [5:0]  last_hout = '0;
    logic [57:0] dsc = SCR_INIT;
    logic [30:0] hist = '0;
    int          hist_fill = 0;
    int          prbs_cnt = 0;
    int          prbs_errs = 0;
    int          und_seen = 0;
    int          idle_sent = 0;

    function automatic logic [31:0] rev32(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    task automatic prbsFeed(input logic b);
        if (hist_fill >= 31 && b !== (hist[30] ^ hist[27])) prbs_errs++;
        hist = {hist[29:0], b};
        hist_fill++;
        prbs_cnt++;
    endtask

    task automatic descramble(input logic [63:0] s, output logic [63:0] p);
        p = '0;
        for (int i = 0; i < 64; i++) begin
            p[i] = s[i] ^ dsc[38] ^ dsc[57];
            dsc  = {dsc[56:0], s[i]};
        end
    endtask

    task automatic resetModel();
        seq_m     = '0;
        half_m    = 1'b0;
        q.delete();
        dsc       = SCR_INIT;
        last_dout = '0;
        last_hout = '0;
        hist_fill = 0;
    endtask

    // Called at a falling edge: drive one cycle, check it, advance the model, wait for next falling edge.
    task automatic step32(input logic v, input logic [63:0] d, input logic [1:0] h, input logic [1:0] m);
        logic        slot;
        logic        exp_ready;
        logic [63:0] blk;
        logic [63:0] plain;
        blk_t        e;
        mode32 = m;
        valid32 = v;
        data32 = d;
        head32 = h;
        #1;
        slot      = !half_m && (seq_m != LAST32);
        exp_ready = slot && (m == 2'b00 || m == 2'b11);
        checkOutput("seq32", 64'(seq32), 64'(seq_m));
        checkOutput("ready32", 64'(ready32), 64'(exp_ready));
        checkOutput("underrun32", 64'(und32), 64'(exp_ready && !v));
        if (und32) und_seen++;
        if (q.size() > 0 && q[0].cyc + 2 == cyc) begin
            low_m = rev32(dout32);
            if (q[0].prbs) begin
                checkOutput("head32 pad", 64'(hout32[5:2]), 64'h0);
                hdr_m = {hout32[0], hout32[1]};
            end else begin
                checkOutput("head32", 64'(hout32), 64'({4'b0000, q[0].head[0], q[0].head[1]}));
            end
        end else if (q.size() > 0 && q[0].cyc + 3 == cyc) begin
            checkOutput("head32 half1", 64'(hout32), 64'h0);
            blk = {rev32(dout32), low_m};
            if (q[0].prbs) begin
                prbsFeed(hdr_m[0]);
                prbsFeed(hdr_m[1]);
                for (int i = 0; i < 64; i++) prbsFeed(blk[i]);
            end else begin
                descramble(blk, plain);
                checkOutput("payload32", plain, q[0].data);
            end
            void'(q.pop_front());
        end else begin
            checkOutput("hold data32", 64'(dout32), 64'(last_dout));
            checkOutput("hold head32", 64'(hout32), 64'(last_hout));
        end
        last_dout = dout32;
        last_hout = hout32;
        if (slot) begin
            if (m == 2'b01) e = '{cyc, 1'b0, 64'h0, 2'b01};
            else if (m == 2'b10) e = '{cyc, 1'b1, 64'h0, 2'b00};
            else if (v) e = '{cyc, 1'b0, d, h};
            else begin
                e = '{cyc, 1'b0, IDLE, 2'b10};
                idle_sent++;
            end
            q.push_back(e);
        end
        if (half_m) begin
            half_m = 1'b0;
            seq_m  = (seq_m == LAST32) ? 7'd0 : seq_m + 7'd1;
        end else begin
            half_m = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int und0;
        int idle0;
        // 64-bit lane, SEQ_LAST=4, bypass: data_o shows the block accepted two cycles earlier.
        vecs[0]  = '{1'b1, P1, 2'b01, 1'b1, 1'b0, 7'd0, 64'h0, 6'h00};
        vecs[1]  = '{1'b1, P2, 2'b01, 1'b1, 1'b0, 7'd1, 64'h0, 6'h00};
        vecs[2]  = '{1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 7'd2, P1, 6'h01};
        vecs[3]  = '{1'b1, P3, 2'b10, 1'b1, 1'b0, 7'd3, P2, 6'h01};
        vecs[4]  = '{1'b1, P4, 2'b01, 1'b0, 1'b0, 7'd4, IDLE, 6'h02};
        vecs[5]  = '{1'b1, P4, 2'b01, 1'b1, 1'b0, 7'd0, P3, 6'h02};
        vecs[6]  = '{1'b1, P5, 2'b01, 1'b1, 1'b0, 7'd1, P3, 6'h02};
        vecs[7]  = '{1'b1, P6, 2'b01, 1'b1, 1'b0, 7'd2, P4, 6'h01};
        vecs[8]  = '{1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 7'd3, P5, 6'h01};
        vecs[9]  = '{1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 7'd4, P6, 6'h01};
        vecs[10] = '{1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 7'd0, IDLE, 6'h02};
        vecs[11] = '{1'b1, P7, 2'b01, 1'b1, 1'b0, 7'd1, IDLE, 6'h02};
        vecs[12] = '{1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 7'd2, IDLE, 6'h02};
        vecs[13] = '{1'b1, P8, 2'b01, 1'b1, 1'b0, 7'd3, P7, 6'h01};
        vecs[14] = '{1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 7'd4, IDLE, 6'h02};
        vecs[15] = '{1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 7'd0, P8, 6'h01};

        valid64 = 1'b1;
        valid32 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset data64", dout64, 64'h0);
        checkOutput("reset head64", 64'(hout64), 64'h0);
        checkOutput("reset seq64", 64'(seq64), 64'h0);
        checkOutput("reset ready64", 64'(ready64), 64'h0);
        checkOutput("reset underrun64", 64'(und64), 64'h0);
        checkOutput("reset data32", 64'(dout32), 64'h0);
        checkOutput("reset ready32", 64'(ready32), 64'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d ready64", i), 64'(ready64), 64'(vecs[i].ready));
            checkOutput($sformatf("row%0d underrun64", i), 64'(und64), 64'(vecs[i].underrun));
            checkOutput($sformatf("row%0d seq64", i), 64'(seq64), 64'(vecs[i].seq));
            checkOutput($sformatf("row%0d data64", i), dout64, vecs[i].dout);
            checkOutput($sformatf("row%0d head64", i), 64'(hout64), 64'(vecs[i].hout));
            @(negedge clk);
        end
        valid64 = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        resetModel();
        rst_n = 1'b1;

        // Random scrambled traffic with occasional gaps and mixed headers.
        for (int i = 0; i < 160; i++) begin
            step32(($urandom_range(0, 7) != 0), {$urandom(), $urandom()},
                   ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 2'b00);
        end

        // Starved source: every load slot becomes an idle block with an underrun pulse.
        und0  = und_seen;
        idle0 = idle_sent;
        for (int i = 0; i < 12; i++) step32(1'b0, 64'h0, 2'b00, 2'b00);
        checkOutput("underrun pulses", 64'(und_seen - und0), 64'(idle_sent - idle0));
        checkOutput("idle slots in gap", 64'((idle_sent - idle0) >= 4), 64'h1);

        // Switch to scrambled-zero while a block is in flight, then back.
        for (int i = 0; i < 30; i++) begin
            step32(1'b1, {$urandom(), $urandom()}, 2'b01, (i < 7) ? 2'b00 : 2'b01);
        end
        for (int i = 0; i < 10; i++) step32(1'b1, {$urandom(), $urandom()}, 2'b10, 2'b11);

        // PRBS31 pattern; source valid toggles but must be ignored.
        for (int i = 0; i < 900; i++) begin
            step32(($urandom_range(0, 1) != 0), {$urandom(), $urandom()}, 2'b01, 2'b10);
        end
        for (int i = 0; i < 8; i++) step32(1'b1, {$urandom(), $urandom()}, 2'b01, 2'b00);
        checkOutput("prbs errors", 64'(prbs_errs), 64'h0);
        checkOutput("prbs bits checked", 64'(prbs_cnt >= 66 * 300), 64'h1);

        // Asynchronous reset while the second half of a block is due.
        for (int i = 0; i < 8 && !(half_m && q.size() > 0); i++) begin
            step32(1'b1, {$urandom(), $urandom()}, 2'b01, 2'b00);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset data32", 64'(dout32), 64'h0);
        checkOutput("async reset head32", 64'(hout32), 64'h0);
        checkOutput("async reset seq32", 64'(seq32), 64'h0);
        checkOutput("async reset ready32", 64'(ready32), 64'h0);
        @(negedge clk);
        resetModel();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step32(1'b1, {$urandom(), $urandom()}, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
